btn_load_ctrl: RTL and testbench
================================

// Module: btn_load_ctrl
// PURPOSE
//   Front-end conditioner for the ALU board top. Synchronizes the raw load
//   button and the data/selector switches, debounces the button, and emits a
//   single-cycle load strobe.
//   With that strobe it presents a stable snapshot of the selector and data
//   switches. Output feeds the downstream register stage: o_load -> its load
//   enable, o_sel -> i_sw, o_dato -> i_dato.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  cycles btn must be stable (10 ms @100 MHz); min 2
//   NB_DATO          6          data switch width (== ALU op width)
//   NB_SEL           2          selector switch width
//   NB_CNT           $clog2(DEBOUNCE_CYCLES)  counter width (localparam, derived)
// PORTS
//   clk       in   1        system clock, all logic on rising edge
//   i_rst_n   in   1        asynchronous active-low reset
//   i_btn     in   1        raw load button, active-high, asynchronous/bouncy
//   i_sw      in   NB_SEL   raw selector switches, asynchronous
//   i_dato    in   NB_DATO  raw data switches, asynchronous
//   o_load    out  1        one-cycle strobe per debounced press
//   o_sel     out  NB_SEL   selector snapshot, valid from o_load cycle onward
//   o_dato    out  NB_DATO  data snapshot, valid from o_load cycle onward
//   o_pressed out  1        debounced button level (high in PRESSED/DB_RELEASE)
// BEHAVIOUR
//   Reset (async, i_rst_n=0): state=IDLE, cnt=0, sync flops=0, o_load=0,
//     o_sel=0, o_dato=0, o_pressed=0. Reset mid-debounce aborts it.
//     A button still held at release of reset needs a full fresh debounce.
//     That debounce yields exactly one strobe.
//   Sync: i_btn, i_sw, i_dato each pass a 2-FF synchronizer -> btn_s, sw_s, dato_s.
//   FSM (cnt counts only in DB_ states, cleared on every state change):
//     IDLE:       btn_s=1 -> DB_PRESS.
//     DB_PRESS:   btn_s=0 -> IDLE (bounce rejected, no strobe).
//                 cnt==DEBOUNCE_CYCLES-1 -> PRESSED; same edge: o_load<=1,
//                 o_sel<=sw_s, o_dato<=dato_s. Otherwise cnt++.
//     PRESSED:    btn_s=0 -> DB_RELEASE. Holding never re-strobes.
//     DB_RELEASE: btn_s=1 -> PRESSED (release bounce, no strobe).
//                 cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++.
//   o_load: registered, high exactly one cycle, then 0 until the next full
//     press/release/press sequence.
//   o_sel/o_dato update only on the o_load edge. They hold between strobes;
//     switch motion at other times is invisible downstream.
//   Latency: i_btn first sampled high at edge r and held stable -> o_load
//     high after edge r+DEBOUNCE_CYCLES+2.
//   cnt never exceeds DEBOUNCE_CYCLES-1 (no wrap). The compare is exact
//     equality on NB_CNT bits.
//   o_sel=2'b11 is passed through unchanged; the consumer ignores it.
//   Any glitch shorter than DEBOUNCE_CYCLES in either direction is filtered.
//   A press pulse of width >= DEBOUNCE_CYCLES+2 cycles is always accepted.
// STRUCTURE
//   Shared header alu_defs.vh: NB_DATO, NB_SEL, selector codes SEL_A=2'b00,
//     SEL_B=2'b01, SEL_OP=2'b10, FSM state encodings (IDLE=0, DB_PRESS=1,
//     PRESSED=2, DB_RELEASE=3).
//   Sub-module sync_2ff #(WIDTH): two-flop synchronizer with async active-low
//     clear to 0. Instantiated once per raw input group (btn, sw, dato).
//   FSM, counter and snapshot registers live in btn_load_ctrl itself.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1 Reset: hold i_rst_n=0 with inputs toggling -> all outputs 0, no o_load.
//   2 Clean press: i_sw=2'b10, i_dato=6'h2A, i_btn=1 held 20 cycles.
//     -> one o_load, high 6 edges after first sample; o_sel=2'b10, o_dato=6'h2A.
//   3 Bounce: i_btn high 2 cycles, low 1, high 2, then low.
//     -> no o_load, o_pressed stays 0.
//   4 Hold then re-press: hold 50 cycles, release 10, press again with
//     i_dato=6'h05 -> exactly two o_load pulses; second snapshot o_dato=6'h05.
//   5 Switch change between strobes: press with i_dato=6'h01, then change to
//     6'h3F without pressing -> o_dato stays 6'h01.
//   6 Reset mid-debounce: assert i_rst_n=0 in DB_PRESS with cnt=2, release
//     while i_btn held -> single o_load after a full DEBOUNCE_CYCLES+2 from
//     reset release.

Source files
------------

// File: rtl/btn_load_ctrl_pkg.sv
// Purpose : shared widths, selector codes and FSM state encoding for the ALU board front end.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package btn_load_ctrl_pkg;

    // Switch widths; the data width matches the ALU operand/op width.
    localparam int ALU_NB_DATO = 6;
    localparam int ALU_NB_SEL  = 2;

    // Selector codes understood by the downstream register stage.
    // Code 2'b11 is not listed: it is passed through and ignored there.
    localparam logic [1:0] SEL_A  = 2'b00;
    localparam logic [1:0] SEL_B  = 2'b01;
    localparam logic [1:0] SEL_OP = 2'b10;

    // Debounce FSM. The encodings are fixed because board-level debug
    // tooling decodes them.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Purpose : two-flop synchronizer for a group of asynchronous inputs, cleared to 0 on reset.
// Latency : 2 clk edges from input change to q.
// Backpressure: none; free-running.
//
// Ports:
//   clk      in  1      sampling clock
//   i_rst_n  in  1      asynchronous active-low clear
//   d        in  WIDTH  asynchronous input group
//   q        out WIDTH  synchronized copy
module sync_2ff
    import btn_load_ctrl_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_load_ctrl.sv
// Purpose : synchronize + debounce the load button, emit one load strobe per press with a switch snapshot.
// Latency : o_load high after edge r+DEBOUNCE_CYCLES+2, r = first edge that samples i_btn high.
// Backpressure: none; the downstream register stage accepts o_load unconditionally.
//
// Ports:
//   clk       in  1        system clock, rising edge
//   i_rst_n   in  1        asynchronous active-low reset
//   i_btn     in  1        raw load button, active-high, bouncy
//   i_sw      in  NB_SEL   raw selector switches
//   i_dato    in  NB_DATO  raw data switches
//   o_load    out 1        one-cycle strobe per debounced press
//   o_sel     out NB_SEL   selector snapshot taken with o_load
//   o_dato    out NB_DATO  data snapshot taken with o_load
//   o_pressed out 1        debounced button level
module btn_load_ctrl
    import btn_load_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NB_DATO         = ALU_NB_DATO,
    parameter int NB_SEL          = ALU_NB_SEL
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_btn,
    input  logic [NB_SEL-1:0]  i_sw,
    input  logic [NB_DATO-1:0] i_dato,
    output logic               o_load,
    output logic [NB_SEL-1:0]  o_sel,
    output logic [NB_DATO-1:0] o_dato,
    output logic               o_pressed
);

    // $clog2(N) bits hold 0..N-1, which is all the counter ever reaches.
    localparam int                NB_CNT   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

    logic               btn_s;
    logic [NB_SEL-1:0]  sw_s;
    logic [NB_DATO-1:0] dato_s;

    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .d       (i_btn),
        .q       (btn_s)
    );

    sync_2ff #(.WIDTH(NB_SEL)) u_sync_sw (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .d       (i_sw),
        .q       (sw_s)
    );

    sync_2ff #(.WIDTH(NB_DATO)) u_sync_dato (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .d       (i_dato),
        .q       (dato_s)
    );

    state_t            state_q, state_d;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic              load_d;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter defaults to 0, so it is cleared on every state change and
    // stays at 0 in IDLE/PRESSED; it only advances while a DB_ state holds.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        load_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    load_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Snapshot registers move only with the strobe, so switch motion between
    // presses never reaches the register stage.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_load <= 1'b0;
            o_sel  <= '0;
            o_dato <= '0;
        end else begin
            o_load <= load_d;
            if (load_d) begin
                o_sel  <= sw_s;
                o_dato <= dato_s;
            end
        end
    end

    assign o_pressed = (state_q == PRESSED) || (state_q == DB_RELEASE);

endmodule

// File: tb/tb_btn_load_ctrl.sv
module tb_btn_load_ctrl;

    localparam int DEB = 4;

    logic       clk;
    logic       i_rst_n;
    logic       i_btn;
    logic [1:0] i_sw;
    logic [5:0] i_dato;
    logic       o_load;
    logic [1:0] o_sel;
    logic [5:0] o_dato;
    logic       o_pressed;

    btn_load_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .NB_DATO         (6),
        .NB_SEL          (2)
    ) dut (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_btn     (i_btn),
        .i_sw      (i_sw),
        .i_dato    (i_dato),
        .o_load    (o_load),
        .o_sel     (o_sel),
        .o_dato    (o_dato),
        .o_pressed (o_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after posedge n (and #1) cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] sel;
        logic [5:0] dato;
        int         at_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   load_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after edge k: first sample at k+1, strobe after edge k+1+DEB+2.
    task automatic press_expect(input logic [1:0] sel, input logic [5:0] dato);
        exp_t e;
        i_sw   = sel;
        i_dato = dato;
        i_btn  = 1'b1;
        e.sel    = sel;
        e.dato   = dato;
        e.at_cyc = cyc + DEB + 3;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest expected snapshot and time.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_load) begin
            load_seen++;
            if (exp_q.size() == 0) begin
                check("load_expected", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("load_cycle", cyc, e.at_cyc);
                check("load_sel", int'(o_sel), int'(e.sel));
                check("load_dato", int'(o_dato), int'(e.dato));
            end
        end
    end

    logic [14:0] bounce_pat;
    logic        any_pressed;

    initial begin
        i_rst_n = 1'b0;
        i_btn   = 1'b0;
        i_sw    = 2'b00;
        i_dato  = 6'h00;

        // 1: reset with inputs toggling
        for (int i = 0; i < 6; i++) begin
            tick(1);
            i_btn  = ~i_btn;
            i_sw   = i_sw + 2'd1;
            i_dato = i_dato + 6'd7;
        end
        tick(1);
        check("rst_load", int'(o_load), 0);
        check("rst_sel", int'(o_sel), 0);
        check("rst_dato", int'(o_dato), 0);
        check("rst_pressed", int'(o_pressed), 0);
        i_btn  = 1'b0;
        i_sw   = 2'b00;
        i_dato = 6'h00;
        tick(1);
        i_rst_n = 1'b1;
        tick(5);

        // 2: clean press
        press_expect(2'b10, 6'h2A);
        tick(20);
        check("clean_pressed_hi", int'(o_pressed), 1);
        i_btn = 1'b0;
        tick(10);
        check("clean_pressed_lo", int'(o_pressed), 0);
        check("clean_load_count", load_seen, 1);

        // 3: bounce shorter than the debounce window
        bounce_pat  = 15'b000_0000_0001_1011;
        any_pressed = 1'b0;
        for (int i = 0; i < 15; i++) begin
            i_btn = bounce_pat[i];
            tick(1);
            any_pressed = any_pressed | o_pressed;
        end
        check("bounce_pressed", int'(any_pressed), 0);
        check("bounce_load_count", load_seen, 1);

        // 4: long hold, release, re-press
        press_expect(2'b01, 6'h11);
        tick(50);
        i_btn = 1'b0;
        tick(10);
        press_expect(2'b01, 6'h05);
        tick(15);
        i_btn = 1'b0;
        tick(10);
        check("hold_load_count", load_seen, 3);
        check("repress_dato", int'(o_dato), 6'h05);

        // 5: switches move between strobes
        press_expect(2'b00, 6'h01);
        tick(15);
        i_btn = 1'b0;
        tick(10);
        i_dato = 6'h3F;
        i_sw   = 2'b11;
        tick(10);
        check("hold_dato", int'(o_dato), 6'h01);
        check("hold_sel", int'(o_sel), 0);
        check("switch_load_count", load_seen, 4);

        // 6: reset in DB_PRESS with cnt==2, button still held at release
        i_sw   = 2'b11;
        i_dato = 6'h15;
        i_btn  = 1'b1;
        tick(5);
        check("mid_pressed", int'(o_pressed), 0);
        i_rst_n = 1'b0;
        tick(3);
        check("mid_rst_dato", int'(o_dato), 0);
        check("mid_rst_load_count", load_seen, 4);
        i_rst_n = 1'b1;
        begin
            exp_t e;
            e.sel    = 2'b11;
            e.dato   = 6'h15;
            e.at_cyc = cyc + DEB + 3;
            exp_q.push_back(e);
        end
        tick(20);
        check("post_rst_pressed", int'(o_pressed), 1);
        i_btn = 1'b0;
        tick(10);
        check("final_load_count", load_seen, 5);
        check("pending_expected", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
